// File: rtl/lighting_scheduler_pkg.sv
// light_pkg: shared types, FSM states and default parameters for lighting_scheduler.
package light_pkg;
  typedef logic [143:0] triangle_t;
  typedef logic [23:0]  rgb_t;
  typedef logic [47:0]  vec3_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} sched_state_t;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MIN_LAT    = 4;
  localparam int DEF_TIMEOUT    = 64;
  localparam int QW             = $bits(triangle_t) + $bits(rgb_t);
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/lighting_scheduler_if.sv
// lighting_scheduler_if: upstream, lighting-unit and downstream signals of the scheduler.
interface lighting_scheduler_if;
  import light_pkg::*;
  logic      in_valid;
  logic      in_ready;
  triangle_t in_tri;
  rgb_t      in_rgb;
  logic      lv_we;
  vec3_t     lv_d;
  logic      lit_en;
  triangle_t lit_tri;
  rgb_t      lit_rgb;
  vec3_t     lit_light_vec;
  logic      lit_valid;
  logic      lit_illuminated;
  rgb_t      lit_rgb_out;
  logic      out_valid;
  logic      out_ready;
  triangle_t out_tri;
  rgb_t      out_rgb;
  logic      busy;
  logic      timeout_err;
  modport master (
    output in_valid, in_tri, in_rgb, lv_we, lv_d, lit_valid, lit_illuminated, lit_rgb_out, out_ready,
    input  in_ready, lit_en, lit_tri, lit_rgb, lit_light_vec, out_valid, out_tri, out_rgb, busy, timeout_err
  );
  modport slave (
    input  in_valid, in_tri, in_rgb, lv_we, lv_d, lit_valid, lit_illuminated, lit_rgb_out, out_ready,
    output in_ready, lit_en, lit_tri, lit_rgb, lit_light_vec, out_valid, out_tri, out_rgb, busy, timeout_err
  );
endinterface

// File: rtl/lighting_scheduler_tri_fifo.sv
// tri_fifo: power-of-two deep queue of {triangle, colour} words with full/empty flags.
module tri_fifo #(
  parameter int WIDTH = 168,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push && !o_full) r_wp <= r_wp + 1'b1;
      if (i_pop && !o_empty) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/lighting_scheduler.sv
// lighting_scheduler: queues triangles, runs one at a time through the lighting unit; LIGHT_SCHED_STATS_EN adds drawn/culled counters.
module lighting_scheduler
  import light_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MIN_LAT    = DEF_MIN_LAT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  lighting_scheduler_if.slave bus
`ifdef LIGHT_SCHED_STATS_EN
  ,
  output logic [15:0] stat_drawn,
  output logic [15:0] stat_culled
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  sched_state_t  r_state, w_next;
  logic [CW-1:0] r_cnt;
  triangle_t     r_tri;
  rgb_t          r_rgb, r_orgb;
  vec3_t         r_pend, r_act;
  logic          r_err;
  logic          w_full, w_empty, w_push, w_pop, w_qual, w_tmo;
  logic [QW-1:0] w_head;
  tri_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({bus.in_tri, bus.in_rgb}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign w_push = bus.in_valid & ~w_full;
  assign w_pop  = (r_state == S_IDLE) & ~w_empty;
  // early valids for unlit faces are masked until MIN_LAT cycles have elapsed
  assign w_qual = (r_state == S_WAIT) & bus.lit_valid & (r_cnt >= CW'(MIN_LAT));
  assign w_tmo  = (r_state == S_WAIT) & ~w_qual & (r_cnt == CW'(TIMEOUT));
  assign bus.in_ready      = ~w_full;
  assign bus.lit_tri       = r_tri;
  assign bus.lit_rgb       = r_rgb;
  assign bus.lit_light_vec = r_act;
  assign bus.out_tri       = r_tri;
  assign bus.out_rgb       = r_orgb;
  assign bus.busy          = ~w_empty | (r_state != S_IDLE);
  assign bus.timeout_err   = r_err;
  always_comb begin
    w_next        = r_state;
    bus.lit_en    = r_state == S_ISSUE;
    bus.out_valid = r_state == S_OUT;
    case (r_state)
      S_IDLE:  w_next = w_empty ? S_IDLE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = w_qual ? (bus.lit_illuminated ? S_OUT : S_IDLE) : (w_tmo ? S_IDLE : S_WAIT);
      S_OUT:   w_next = bus.out_ready ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tri   <= '0;
      r_rgb   <= '0;
      r_orgb  <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.lv_we) r_pend <= bus.lv_d;
      // a write landing in the pop cycle goes straight to the active vector
      if (r_state == S_IDLE) r_act <= bus.lv_we ? bus.lv_d : r_pend;
      if (w_pop) {r_tri, r_rgb} <= w_head;
      r_cnt <= (r_state == S_ISSUE) ? CW'(1) : (r_state == S_WAIT) ? r_cnt + 1'b1 : r_cnt;
      if (w_qual && bus.lit_illuminated) r_orgb <= bus.lit_rgb_out;
      if (w_tmo) r_err <= 1'b1;
    end
  end
`ifdef LIGHT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_drawn  <= '0;
      stat_culled <= '0;
    end else begin
      if (r_state == S_OUT && bus.out_ready) stat_drawn <= sat_inc(stat_drawn);
      if (w_qual && !bus.lit_illuminated) stat_culled <= sat_inc(stat_culled);
    end
  end
`endif
endmodule

// File: tb/tb_lighting_scheduler.sv
// tb_lighting_scheduler: directed table, corner sequences and randomized scoreboard for lighting_scheduler.
module tb_lighting_scheduler;
  import light_pkg::*;
  localparam int MIN_LAT = 4;
  localparam int TIMEOUT = 64;
  localparam int K_DRAW = 0, K_CULL = 1, K_TMO = 2, K_HANG = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lighting_scheduler_if bus ();
`ifdef LIGHT_SCHED_STATS_EN
  logic [15:0] stat_drawn, stat_culled;
`endif
  lighting_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef LIGHT_SCHED_STATS_EN
    ,
    .stat_drawn  (stat_drawn),
    .stat_culled (stat_culled)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int n_en = 0;
  int lu_wc = 1000;
  logic lu_on = 1'b0;
  typedef struct {
    int   dly;
    logic ill;
    rgb_t ro;
    int   early;
    int   kind;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string n, input logic [167:0] a, input logic [167:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic triangle_t rnd_tri();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_tri = '0;
    bus.in_rgb = '0;
    bus.lv_we = 1'b0;
    bus.lv_d = '0;
    bus.lit_valid = 1'b0;
    bus.lit_illuminated = 1'b0;
    bus.lit_rgb_out = '0;
    bus.out_ready = 1'b0;
    lu_on = 1'b0;
    lu_wc = 1000;
    n_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  // tick with an auto-responding lighting unit: lit result on the 4th WAIT cycle
  task automatic tick_lu();
    @(negedge clk);
    if (bus.lit_en) begin
      n_en++;
      lu_wc = 0;
    end else lu_wc++;
    bus.lit_valid = lu_on && lu_wc == 4;
    bus.lit_illuminated = 1'b1;
    bus.lit_rgb_out = 24'h5A5A5A;
  endtask
  task automatic job(input int dly, input logic ill, input rgb_t ro, input int early,
                     output int kind, output rgb_t got, output int lat);
    kind = K_HANG;
    got = '0;
    lat = 0;
    bus.in_valid = 1'b1;
    bus.in_tri = rnd_tri();
    bus.in_rgb = 24'hFFFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (bus.lit_en) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) return;
    for (int wc = 1; wc <= 80; wc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        kind = K_DRAW;
        got = bus.out_rgb;
        bus.lit_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        break;
      end
      if (!bus.busy) begin
        kind = bus.timeout_err ? K_TMO : K_CULL;
        break;
      end
      bus.lit_valid = (wc == dly) || (wc == early);
      bus.lit_illuminated = (wc == dly) && ill;
      bus.lit_rgb_out = ro;
    end
    bus.lit_valid = 1'b0;
  endtask
  initial begin
    int kind, lat, cnt_ov;
    rgb_t got;
    vec3_t exp_lv;
    tbl[0] = '{6, 1'b1, 24'h808080, 0, K_DRAW};
    tbl[1] = '{5, 1'b0, 24'h000000, 1, K_CULL};
    tbl[2] = '{4, 1'b1, 24'h123456, 0, K_DRAW};
    tbl[3] = '{3, 1'b1, 24'h111111, 0, K_TMO};
    tbl[4] = '{64, 1'b0, 24'h222222, 0, K_CULL};
    tbl[5] = '{64, 1'b1, 24'hABCDEF, 2, K_DRAW};
    tbl[6] = '{65, 1'b1, 24'h333333, 0, K_TMO};
    tbl[7] = '{0, 1'b1, 24'h444444, 3, K_TMO};
    do_reset();
    chk("rst_lit_en", bus.lit_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_vec", bus.lit_light_vec, 0);
`ifdef LIGHT_SCHED_STATS_EN
    chk("rst_drawn", stat_drawn, 0);
    chk("rst_culled", stat_culled, 0);
`endif
    foreach (tbl[r]) begin
      do_reset();
      job(tbl[r].dly, tbl[r].ill, tbl[r].ro, tbl[r].early, kind, got, lat);
      chk($sformatf("tbl%0d_lat", r), lat, 2);
      chk($sformatf("tbl%0d_kind", r), kind, tbl[r].kind);
      if (tbl[r].kind == K_DRAW) chk($sformatf("tbl%0d_rgb", r), got, tbl[r].ro);
      chk($sformatf("tbl%0d_err", r), bus.timeout_err, tbl[r].kind == K_TMO);
`ifdef LIGHT_SCHED_STATS_EN
      chk($sformatf("tbl%0d_drawn", r), stat_drawn, tbl[r].kind == K_DRAW);
      chk($sformatf("tbl%0d_culled", r), stat_culled, tbl[r].kind == K_CULL);
`endif
    end
    do_reset();
    lu_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_tri = rnd_tri();
      bus.in_rgb = 24'(i);
      tick_lu();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", bus.in_ready, 0);
    repeat (20) tick_lu();
    chk("full_one_lit_en", n_en, 1);
    chk("full_out_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (60) tick_lu();
    chk("full_all_issued", n_en, 5);
    chk("full_drained", bus.busy, 0);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_tri = rnd_tri();
    tick_lu();
    bus.in_tri = rnd_tri();
    tick_lu();
    bus.in_valid = 1'b0;
    chk("tmo_first_en", n_en, 1);
    repeat (64) tick_lu();
    chk("tmo_not_yet", bus.timeout_err, 0);
    tick_lu();
    chk("tmo_set", bus.timeout_err, 1);
    tick_lu();
    chk("tmo_next_issued", n_en, 2);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_tri = rnd_tri();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.lv_we = 1'b1;
    bus.lv_d = 48'h7;
    @(negedge clk);
    bus.lv_we = 1'b0;
    chk("pop_lv_en", bus.lit_en, 1);
    chk("pop_lv_vec", bus.lit_light_vec, 48'h7);
    do_reset();
    bus.lv_we = 1'b1;
    bus.lv_d = 48'hA;
    @(negedge clk);
    bus.lv_we = 1'b0;
    chk("lv_idle_load", bus.lit_light_vec, 48'hA);
    bus.in_valid = 1'b1;
    bus.in_tri = rnd_tri();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.lv_we = 1'b1;
    bus.lv_d = 48'h1;
    @(negedge clk);
    bus.lv_d = 48'h2;
    @(negedge clk);
    bus.lv_we = 1'b0;
    chk("lv_wait_hold", bus.lit_light_vec, 48'hA);
    repeat (2) @(negedge clk);
    bus.lit_valid = 1'b1;
    bus.lit_illuminated = 1'b0;
    @(negedge clk);
    bus.lit_valid = 1'b0;
    chk("lv_hold_to_idle", bus.lit_light_vec, 48'hA);
    @(negedge clk);
    chk("lv_idle_copy", bus.lit_light_vec, 48'h2);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_tri = rnd_tri();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_ov = 0;
    bus.lit_valid = 1'b1;
    bus.lit_illuminated = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) cnt_ov++;
    end
    bus.lit_valid = 1'b0;
    chk("rstwait_no_out", cnt_ov, 0);
    chk("rstwait_busy", bus.busy, 0);
    chk("rstwait_in_ready", bus.in_ready, 1);
    begin
      triangle_t inq_t[$];
      rgb_t inq_c[$];
      logic [167:0] expq[$];
      logic act_job, ill, exp_err;
      triangle_t cur;
      rgb_t ro;
      int wc, m, e, exp_drawn, exp_culled;
      do_reset();
      exp_lv = {$urandom, 16'(
$urandom)};
      bus.lv_we = 1'b1;
      bus.lv_d = exp_lv;
      @(negedge clk);
      bus.lv_we = 1'b0;
      act_job = 1'b0;
      exp_err = 1'b0;
      exp_drawn = 0;
      exp_culled = 0;
      wc = 0;
      m = 0;
      e = 0;
      ill = 1'b0;
      ro = '0;
      cur = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        @(negedge clk);
        if (bus.lit_en) begin
          chk("rnd_one_in_flight", act_job, 0);
          chk("rnd_lit_has_job", inq_t.size() != 0, 1);
          if (inq_t.size() != 0) begin
            cur = inq_t.pop_front();
            chk("rnd_lit_tri", bus.lit_tri, cur);
            chk("rnd_lit_rgb", bus.lit_rgb, inq_c.pop_front());
          end
          chk("rnd_lit_vec", bus.lit_light_vec, exp_lv);
          act_job = 1'b1;
          wc = 0;
          m = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 + $urandom_range(0, 4) :
              ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(MIN_LAT, 20);
          e = $urandom_range(0, MIN_LAT - 1);
          ill = 1'($urandom);
          ro = 24'($urandom);
        end else if (act_job) wc++;
        bus.lit_valid = act_job && wc > 0 && (wc == e || wc == m);
        bus.lit_illuminated = (wc == m) ? ill : 1'($urandom);
        bus.lit_rgb_out = (wc == m) ? ro : 24'($urandom);
        if (act_job && wc == m && m <= TIMEOUT) begin
          if (ill) expq.push_back({cur, ro});
          else exp_culled++;
          act_job = 1'b0;
        end
        if (act_job && wc == TIMEOUT && m > TIMEOUT) begin
          exp_err = 1'b1;
          act_job = 1'b0;
        end
        bus.out_ready = $urandom_range(0, 3) != 0;
        if (bus.out_valid) chk("rnd_out_expected", expq.size() != 0, 1);
        if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
          chk("rnd_out", {bus.out_tri, bus.out_rgb}, expq.pop_front());
          exp_drawn++;
        end
        bus.in_valid = (cyc < 3300) && 1'($urandom);
        bus.in_tri = rnd_tri();
        bus.in_rgb = 24'($urandom);
        if (bus.in_valid && bus.in_ready) begin
          inq_t.push_back(bus.in_tri);
          inq_c.push_back(bus.in_rgb);
        end
      end
      chk("rnd_drain_in", inq_t.size(), 0);
      chk("rnd_drain_out", expq.size(), 0);
      chk("rnd_idle", bus.busy, 0);
      chk("rnd_timeout_err", bus.timeout_err, exp_err);
`ifdef LIGHT_SCHED_STATS_EN
      chk("rnd_drawn", stat_drawn, 16'(exp_drawn));
      chk("rnd_culled", stat_culled, 16'(exp_culled));
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lighting_scheduler.md
LIGHTING_SCHEDULER -- requirements
Module: lighting_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the input triangle queue depth (power of two, >=2).
REQ-002 Parameter MIN_LAT, default 4, SHALL set the cycles after lit_en during which lit_valid is ignored.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the WAIT-state cycle limit before a job is abandoned.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream triangle offer.
- in_ready  out  1  queue not full.
- in_tri  in  144  three 48-bit vertices, v0 in [143:96].
- in_rgb  in  24  base colour.
- lv_we  in  1  light-vector write strobe.
- lv_d  in  48  new light vector.
- lit_en  out  1  one-cycle start pulse to the lighting unit.
- lit_tri  out  144  triangle presented to the lighting unit.
- lit_rgb  out  24  colour presented to the lighting unit.
- lit_light_vec  out  48  active light vector.
- lit_valid  in  1  lighting unit done.
- lit_illuminated  in  1  lighting unit front-facing flag.
- lit_rgb_out  in  24  shaded colour.
- out_valid  out  1  shaded triangle offer downstream.
- out_ready  in  1  downstream accept.
- out_tri  out  144  shaded triangle.
- out_rgb  out  24  shaded colour.
- busy  out  1  queue non-empty or state != IDLE.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-005 Input handshake SHALL complete when in_valid & in_ready; the triangle and colour are written to the queue tail that cycle.
REQ-006 in_ready SHALL be low when the queue is full, including a cycle in which a pop occurs (no same-cycle full bypass).
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT, OUT.
REQ-008 In IDLE with a non-empty queue, the head SHALL be popped into a working register and the FSM SHALL go to ISSUE.
REQ-009 ISSUE SHALL assert lit_en for exactly one cycle, then go to WAIT; lit_tri/lit_rgb SHALL stay stable from ISSUE until the FSM returns to IDLE.
REQ-010 A triangle accepted in cycle T into an empty, idle block SHALL see lit_en high in cycle T+2.
REQ-011 WAIT SHALL count cycles from 1; lit_valid SHALL be ignored while count < MIN_LAT, which masks the lighting unit's early valid for unlit faces.
REQ-012 In WAIT, lit_valid with lit_illuminated=1 SHALL capture lit_rgb_out into out_rgb and go to OUT.
REQ-013 In WAIT, lit_valid with lit_illuminated=0 SHALL cull the triangle (no output) and return to IDLE.
REQ-014 When the WAIT count reaches TIMEOUT without a qualified lit_valid, timeout_err SHALL be set, the triangle dropped, and the FSM SHALL return to IDLE.
REQ-015 OUT SHALL hold out_valid, out_tri and out_rgb stable until out_ready, then return to IDLE; out_valid SHALL NOT depend combinationally on out_ready.
REQ-016 lv_we SHALL load a pending register at any time; pending SHALL copy to the active light vector only in IDLE.
REQ-017 An lv_we in the same IDLE cycle as a pop SHALL update the active vector, and the popped triangle SHALL use the new vector.
REQ-018 Only one triangle SHALL be in the lighting unit at a time.

Reset
REQ-019 On rst=1, the FSM SHALL go to IDLE and the queue SHALL empty.
REQ-020 On rst=1, lit_en, out_valid, busy and timeout_err SHALL go to 0, in_ready to 1, and active/pending light vectors to 0.
REQ-021 rst in any state, including mid-WAIT, SHALL discard the in-flight job; late lit_valid SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-022 With LIGHT_SCHED_STATS_EN defined, 16-bit outputs stat_drawn and stat_culled SHALL exist.
REQ-023 stat_drawn SHALL count OUT handshakes and stat_culled SHALL count REQ-013 culls; both saturate at 16'hFFFF and reset to 0.
REQ-024 Without LIGHT_SCHED_STATS_EN, these ports and counters SHALL NOT exist.

Structure
REQ-025 Package light_pkg SHALL hold: triangle_t (144 b), rgb_t (24 b), vec3_t (48 b), state enum sched_state_t, and default parameter constants.
REQ-026 The queue SHALL be a sub-module named tri_fifo (width 168, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-027 Single lit triangle, in_rgb=24'hFFFFFF, model returns illuminated=1 and rgb 24'h808080 at cycle 6 -> lit_en at T+2, out_rgb=24'h808080, stat_drawn=1.
REQ-028 Model returns illuminated=0 with valid at cycle 1 and again at cycle 5 -> cycle-1 valid ignored, culled at cycle 5, out_valid never high, stat_culled=1.
REQ-029 Push 5 triangles back-to-back with out_ready=0 -> in_ready drops after 4 queued plus 1 in flight; exactly one lit_en until out_ready rises.
REQ-030 Model never asserts lit_valid -> timeout_err=1 after 64 WAIT cycles, FSM returns to IDLE, next triangle is issued.
REQ-031 lv_d=48'h1 while in WAIT, then lv_d=48'h2 -> lit_light_vec unchanged until IDLE, then 48'h2.
REQ-032 rst asserted mid-WAIT, then model lit_valid -> no out_valid, busy=0, in_ready=1.
